// File: rtl/riscv_soc_pkg.sv
// Shared SoC definitions for the serial transmit path: UART frame geometry,
// the default baud divider and the arbiter state encoding.
package riscv_soc_pkg;

   // Start bit + 8 data bits + stop bit.
   localparam int UART_FRAME_BITS      = 10;
   // 50 MHz core clock / 115200 baud.
   localparam int UART_DEFAULT_CLK_DIV = 434;

   typedef enum logic {
      ARB_UNLOCKED = 1'b0,
      ARB_LOCKED   = 1'b1
   } arb_state_e;

endpackage : riscv_soc_pkg

// File: rtl/uart_tx_shift.sv
// 8N1 UART transmit shifter. A load pulse latches one byte and starts a
// frame immediately on the next cycle; busy stays high until the stop bit
// has been held for a full bit period. The line idles high.
module uart_tx_shift
   import riscv_soc_pkg::*;
#(
   parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       ser_tx
);

   localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [3:0]       BIT_LAST = 4'(UART_FRAME_BITS - 1);

   logic             busy_q, busy_d;
   logic             ser_q, ser_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   // Remaining data bits with the stop bit parked above them; bit 0 is the
   // next bit to drive onto the line.
   logic [8:0]       sh_q, sh_d;
   logic             bit_end;

   assign bit_end = busy_q && (cnt_q == CNT_LAST);

   // Next-state: start a frame on load, otherwise advance the bit timer and
   // step to the next frame bit at the end of each bit period.
   always_comb begin
      busy_d = busy_q;
      ser_d  = ser_q;
      cnt_d  = cnt_q;
      bit_d  = bit_q;
      sh_d   = sh_q;
      if (load) begin
         busy_d = 1'b1;
         ser_d  = 1'b0;
         cnt_d  = '0;
         bit_d  = '0;
         sh_d   = {1'b1, data};
      end else if (busy_q) begin
         if (bit_end) begin
            cnt_d = '0;
            if (bit_q == BIT_LAST) begin
               busy_d = 1'b0;
               ser_d  = 1'b1;
            end else begin
               bit_d = bit_q + 4'd1;
               ser_d = sh_q[0];
               sh_d  = {1'b1, sh_q[8:1]};
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Control state: an asserted reset drops any partial frame and returns
   // the line to idle high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         ser_q  <= 1'b1;
         cnt_q  <= '0;
         bit_q  <= '0;
      end else begin
         busy_q <= busy_d;
         ser_q  <= ser_d;
         cnt_q  <= cnt_d;
         bit_q  <= bit_d;
      end
   end

   // Shift data carries no reset; it is only observed while busy.
   always_ff @(posedge clk) begin
      sh_q <= sh_d;
   end

   assign busy   = busy_q;
   assign ser_tx = ser_q;

endmodule : uart_tx_shift

// File: rtl/uart_tx_sched.sv
// Shares the serial transmit line between NUM_REQ byte-stream requesters.
// Round-robin arbitration picks an owner, which keeps the line until it sends
// a byte flagged last or stays idle for TIMEOUT_BITS bit periods. Accepted
// bytes are handed to the 8N1 shifter.
module uart_tx_sched
   import riscv_soc_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int CLK_DIV      = UART_DEFAULT_CLK_DIV,
   parameter int TIMEOUT_BITS = 16
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 ser_tx
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               TO_LIMIT = TIMEOUT_BITS * CLK_DIV;
   localparam int               TMR_W    = $clog2(TO_LIMIT + 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TO_LIMIT);
   localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TO_LIMIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   logic             own_valid;
   logic             own_last;
   logic [7:0]       own_data;
   logic             accept;
   logic             idle;
   logic             timeout;
   logic             release_lock;
   logic             sh_busy;

   // First valid requester at or after ptr, wrapping around.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] sel;
      logic             found;
      int               idx;
      sel   = ptr;
      found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = (int'(ptr) + off) % NUM_REQ;
         if (!found && vld[IDX_W'(idx)]) begin
            sel   = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   // Requester index after idx, modulo NUM_REQ.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
   endfunction

   // Select the current owner's request signals.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[i*8 +: 8];
         end
      end
   end

   assign accept       = (state_q == ARB_LOCKED) && !sh_busy && own_valid;
   assign idle         = (state_q == ARB_LOCKED) && !sh_busy && !own_valid;
   assign timeout      = idle && (tmr_q >= TMR_FIRE);
   assign release_lock = (accept && own_last) || timeout;

   // Arbiter next-state: lock onto a requester, release on last or timeout,
   // and run the idle timer while locked.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      tmr_d   = tmr_q;
      case (state_q)
         ARB_UNLOCKED: begin
            tmr_d = '0;
            if (|req_valid) begin
               state_d = ARB_LOCKED;
               owner_d = rr_pick(req_valid, rr_q);
            end
         end
         ARB_LOCKED: begin
            if (release_lock) begin
               state_d = ARB_UNLOCKED;
               rr_d    = next_idx(owner_q);
               tmr_d   = '0;
            end else if (own_valid) begin
               // An accept always has own_valid set, so this covers both.
               tmr_d = '0;
            end else if (idle) begin
               tmr_d = (tmr_q == TMR_MAX) ? TMR_MAX : tmr_q + TMR_W'(1);
            end
         end
      endcase
   end

   // Arbiter state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ARB_UNLOCKED;
         owner_q <= '0;
         rr_q    <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         tmr_q   <= tmr_d;
      end
   end

   // One-hot grant decoded from the registered owner.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = (state_q == ARB_LOCKED) && (owner_q == IDX_W'(i));
      end
   end

   assign req_ready = grant & {NUM_REQ{~sh_busy}};
   assign busy      = sh_busy;

   uart_tx_shift #(
      .CLK_DIV (CLK_DIV)
   ) u_shift (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .data   (own_data),
      .busy   (sh_busy),
      .ser_tx (ser_tx)
   );

endmodule : uart_tx_sched

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with CLK_DIV = 4, TIMEOUT_BITS = 2, two requesters.
module tb_uart_tx_sched;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } byte_t;

   typedef struct {
      logic       vld0;
      logic [1:0] e_grant;
      logic [1:0] e_ready;
      logic       e_busy;
      logic       e_ser;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [1:0]  grant;
   logic        busy;
   logic        ser_tx;

   int          n_checks = 0;
   int          n_err    = 0;
   int          cyc      = 0;
   int          early    = 0;

   byte_t       src0_q[$];
   byte_t       src1_q[$];
   logic [7:0]  exp_q[$];
   int          acc_req_q[$];
   int          acc_cyc_q[$];
   vec_t        tbl[43];

   uart_tx_sched #(
      .NUM_REQ      (2),
      .CLK_DIV      (4),
      .TIMEOUT_BITS (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .busy      (busy),
      .ser_tx    (ser_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // UART receiver model: samples mid-bit, compares each frame with the scoreboard.
   initial begin
      logic       rx_act;
      logic       rx_start;
      logic [7:0] rx_sh;
      logic [7:0] e;
      int         rx_t;
      rx_act = 1'b0;
      rx_start = 1'b1;
      rx_sh = '0;
      rx_t = 0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            rx_act = 1'b0;
         end else if (!rx_act) begin
            if (ser_tx === 1'b0) begin
               rx_act = 1'b1;
               rx_t = 0;
            end
         end else begin
            rx_t++;
            if (rx_t == 2) begin
               rx_start = ser_tx;
            end else if (rx_t >= 6 && rx_t <= 34 && (rx_t % 4) == 2) begin
               rx_sh = {ser_tx, rx_sh[7:1]};
            end else if (rx_t == 38) begin
               rx_act = 1'b0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL rx_unexpected: got byte 0x%0h, no byte expected", rx_sh);
               end else begin
                  e = exp_q.pop_front();
                  check("rx_frame", 32'({ser_tx, rx_sh, rx_start}), 32'({1'b1, e, 1'b0}));
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      req_valid = 2'b11;
      req_last = 2'b00;
      req_data = 16'h0000;
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      acc_req_q.delete();
      acc_cyc_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ser", 32'(ser_tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      req_valid = 2'b00;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_heads();
      req_valid = 2'b00;
      req_last = 2'b00;
      req_data = 16'h0000;
      if (src0_q.size() > 0) begin
         req_valid[0] = 1'b1;
         req_data[7:0] = src0_q[0].data;
         req_last[0] = src0_q[0].last;
      end
      if (src1_q.size() > 0) begin
         req_valid[1] = 1'b1;
         req_data[15:8] = src1_q[0].data;
         req_last[1] = src1_q[0].last;
      end
   endtask

   // Present queued bytes every cycle and log each handshake until all frames drain.
   task automatic run_streams(input int max_cycles, input bit chk_lock);
      logic [1:0] acc;
      bit         done;
      bit         lock_open;
      byte_t      tmp;
      done = 1'b0;
      lock_open = !chk_lock;
      early = 0;
      for (int c = 0; c < max_cycles && !done; c++) begin
         drive_heads();
         @(negedge clk);
         if (!lock_open && req_ready[1]) early++;
         acc = req_valid & req_ready;
         if (acc[0]) begin
            acc_req_q.push_back(0);
            acc_cyc_q.push_back(cyc);
            if (req_last[0]) lock_open = 1'b1;
         end
         if (acc[1]) begin
            acc_req_q.push_back(1);
            acc_cyc_q.push_back(cyc);
         end
         if (src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0 && !busy)
            done = 1'b1;
         @(posedge clk);
         #1;
         if (acc[0]) tmp = src0_q.pop_front();
         if (acc[1]) tmp = src1_q.pop_front();
      end
      drive_heads();
      check("stream_done", 32'(done), 32'd1);
   endtask

   task automatic wait_drain(input int max_cycles);
      bit done;
      done = 1'b0;
      for (int c = 0; c < max_cycles && !done; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      @(posedge clk);
      #1;
      check("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      logic [9:0] frame;
      int         exp_r[4];
      int         n;
      bit         fell;

      reset = 1'b0;
      req_valid = 2'b00;
      req_last = 2'b00;
      req_data = 16'h0000;

      // Single-byte vector table: row j is cycle N+j, N = first cycle after reset.
      frame = {1'b1, 8'hA5, 1'b0};
      for (int j = 0; j < 43; j++) begin
         tbl[j].vld0 = (j <= 1);
         tbl[j].e_grant = (j == 1) ? 2'b01 : 2'b00;
         tbl[j].e_ready = (j == 1) ? 2'b01 : 2'b00;
         tbl[j].e_busy = (j >= 2 && j <= 41);
         tbl[j].e_ser = (j >= 2 && j <= 41) ? frame[(j - 2) / 4] : 1'b1;
      end

      // ---- single byte 0xA5 with last from req0
      do_reset();
      req_data = 16'h00A5;
      req_last = 2'b01;
      exp_q.push_back(8'hA5);
      for (int j = 0; j < 43; j++) begin
         req_valid = {1'b0, tbl[j].vld0};
         @(negedge clk);
         check($sformatf("sb_grant[%0d]", j), 32'(grant), 32'(tbl[j].e_grant));
         check($sformatf("sb_ready[%0d]", j), 32'(req_ready), 32'(tbl[j].e_ready));
         check($sformatf("sb_busy[%0d]", j), 32'(busy), 32'(tbl[j].e_busy));
         check($sformatf("sb_ser[%0d]", j), 32'(ser_tx), 32'(tbl[j].e_ser));
         @(posedge clk);
         #1;
      end
      req_valid = 2'b00;
      check("sb_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      // ---- locking: req0 three-byte message while req1 waits
      do_reset();
      src0_q.push_back('{data: 8'h11, last: 1'b0});
      src0_q.push_back('{data: 8'h22, last: 1'b0});
      src0_q.push_back('{data: 8'h33, last: 1'b1});
      src1_q.push_back('{data: 8'h44, last: 1'b1});
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      run_streams(400, 1'b1);
      check("lock_ready1_early", 32'(early), 32'd0);
      exp_r = '{0, 0, 0, 1};
      check("lock_accepts", 32'(acc_req_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < acc_req_q.size())
            check($sformatf("lock_req[%0d]", i), 32'(acc_req_q[i]), 32'(exp_r[i]));

      // ---- round-robin: single-byte messages from both requesters
      do_reset();
      src0_q.push_back('{data: 8'hA0, last: 1'b1});
      src0_q.push_back('{data: 8'hA1, last: 1'b1});
      src1_q.push_back('{data: 8'hB0, last: 1'b1});
      src1_q.push_back('{data: 8'hB1, last: 1'b1});
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'hB0);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'hB1);
      run_streams(400, 1'b0);
      exp_r = '{0, 1, 0, 1};
      check("rr_accepts", 32'(acc_req_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < acc_req_q.size())
            check($sformatf("rr_req[%0d]", i), 32'(acc_req_q[i]), 32'(exp_r[i]));

      // ---- timeout: req0 sends one byte without last, then goes quiet
      do_reset();
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'hD4);
      req_data = 16'hD4C3;
      req_last = 2'b10;
      req_valid = 2'b11;
      @(negedge clk);
      check("to_unlocked", 32'(grant), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("to_grant0", 32'(grant), 32'b01);
      check("to_ready0", 32'(req_ready), 32'b01);
      @(posedge clk);
      #1;
      req_valid = 2'b10;
      n = 0;
      fell = 1'b0;
      for (int c = 0; c < 60 && !fell; c++) begin
         @(negedge clk);
         n++;
         if (!busy) fell = 1'b1;
      end
      check("to_busy_cycles", 32'(n), 32'd41);
      check("to_owner_kept", 32'(grant), 32'b01);
      early = 0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (req_ready[1]) early++;
      end
      check("to_hold_idle7", 32'(grant), 32'b01);
      @(negedge clk);
      if (req_ready[1]) early++;
      check("to_release_idle8", 32'(grant), 32'd0);
      check("to_no_ready1", 32'(early), 32'd0);
      @(negedge clk);
      check("to_grant1", 32'(grant), 32'b10);
      check("to_ready1", 32'(req_ready), 32'b10);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      wait_drain(200);

      // ---- reset asserted during data bit 3
      do_reset();
      exp_q.push_back(8'hE7);
      req_data = 16'h00E7;
      req_last = 2'b01;
      req_valid = 2'b01;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      repeat (17) @(posedge clk);
      #3;
      check("mf_bit3_ser", 32'(ser_tx), 32'd0);
      check("mf_bit3_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("mf_rst_ser", 32'(ser_tx), 32'd1);
      check("mf_rst_busy", 32'(busy), 32'd0);
      check("mf_rst_grant", 32'(grant), 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      src0_q.push_back('{data: 8'h5C, last: 1'b1});
      exp_q.push_back(8'h5C);
      run_streams(200, 1'b0);
      check("mf_after_accepts", 32'(acc_req_q.size()), 32'd1);

      // ---- throughput: req1 streams four bytes
      do_reset();
      src1_q.push_back('{data: 8'h10, last: 1'b0});
      src1_q.push_back('{data: 8'h20, last: 1'b0});
      src1_q.push_back('{data: 8'h30, last: 1'b0});
      src1_q.push_back('{data: 8'h40, last: 1'b1});
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h40);
      run_streams(400, 1'b0);
      check("tp_accepts", 32'(acc_cyc_q.size()), 32'd4);
      for (int i = 1; i < 4; i++)
         if (i < acc_cyc_q.size())
            check($sformatf("tp_gap[%0d]", i), 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd41);
      for (int i = 0; i < 4; i++)
         if (i < acc_req_q.size())
            check($sformatf("tp_req[%0d]", i), 32'(acc_req_q[i]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule : tb_uart_tx_sched
